schedule_2nd: RTL
=================

# schedule_2nd

Second scheduling stage of the core pipeline: the issue/operand-fetch point between schedule_1st and the execute stage. It takes the instruction fields held by schedule_1st, reads source operands from the register file, and tracks outstanding destination writes in a 31-entry busy scoreboard. It issues the instruction to execute one cycle later with operand data, or holds it and raises STALL on a RAW or WAW hazard.

## Interface
- No parameters.
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- FLUSH  in  1  synchronous pipeline flush
- MEM_WAIT  in  1  global memory hold
- SCHEDULE_1ST_PC / _IMM  in  32 each  instruction address / immediate
- SCHEDULE_1ST_OPCODE / _FUNCT7  in  7 each  opcode / funct7; OPCODE 7'b0 = bubble
- SCHEDULE_1ST_RD / _RS1 / _RS2  in  5 each  destination / source register indices
- SCHEDULE_1ST_FUNCT3  in  3  funct3
- REG_RS1_ADDR / REG_RS2_ADDR  out  5 each  register-file read addresses (combinational = SCHEDULE_1ST_RS1/RS2)
- REG_RS1_DATA / REG_RS2_DATA  in  32 each  register-file read data, same cycle
- WB_VALID  in  1  writeback commit strobe
- WB_RD  in  5  register index being written back
- WB_DATA  in  32  writeback data
- STALL  out  1  hazard hold to upstream, combinational
- SCHEDULE_2ND_VALID  out  1  issued instruction valid
- SCHEDULE_2ND_PC / _OPCODE / _RD / _FUNCT3 / _FUNCT7 / _IMM  out  as inputs  registered fields
- SCHEDULE_2ND_RS1_DATA / _RS2_DATA  out  32 each  registered operands

## Operation
- Decode, combinational from OPCODE via package function: use_rs1, use_rs2, writes_rd. writes_rd is forced 0 when RD = 0.
- valid_in = (OPCODE != 0).
- Scoreboard: busy[31:1]. x0 is never busy.
- hazard = valid_in && ((use_rs1 && busy_eff[RS1]) || (use_rs2 && busy_eff[RS2]) || (writes_rd && busy[RD])). WAW stalls because each register has only one busy bit.
- STALL = hazard. It is not asserted for MEM_WAIT; upstream sees MEM_WAIT directly.
- Edge update, priority order:
  - FLUSH: output register cleared to bubble; all busy bits cleared.
  - MEM_WAIT: output register and issue path hold; WB clears are still applied.
  - hazard: output register loads a bubble (VALID=0, all fields 0); input is held upstream.
  - otherwise: output register captures fields and operands; VALID = valid_in; if valid_in && writes_rd, set busy[RD].
- WB: when WB_VALID and WB_RD != 0, clear busy[WB_RD] at the edge. This is applied in every branch except FLUSH.
- Same-edge set and clear on the same register: set wins, because the issuing instruction is younger.
- Operand source with the macro off: REG_RSx_DATA. busy_eff = busy.

## Timing
- Issue latency: 1 cycle from schedule_1st fields to SCHEDULE_2ND_* outputs.
- Reset (RST_N low, asynchronous): all outputs 0, VALID 0, all busy bits 0. STALL = 0, since the inputs are bubble after reset.
- Reset release mid-operation: no busy bits survive; any in-flight WB is harmless.
- Dependent instruction, macro off: stalls until the cycle after the WB edge. Minimum one stall cycle even when WB arrives in the same cycle as the consumer.
- FLUSH and hazard together: FLUSH wins; STALL may be high that cycle, upstream is flushed anyway.
- WB for a register that is not busy (e.g. after FLUSH): no effect.

## Configuration
- SCHEDULE_2ND_FORWARD_EN defined:
  - If WB_VALID && WB_RD == RSx && RSx != 0, busy_eff[RSx] = 0 and the operand is WB_DATA. This removes the same-cycle stall.
  - RS1 and RS2 are forwarded independently.
  - WAW check still uses raw busy[RD].
- Undefined: no forwarding mux; behaviour as in Operation.

## Structure
- Shared package core_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM) and function decode_use(opcode) returning {use_rs1, use_rs2, writes_rd}.
- One sub-module, reg_scoreboard:
  - Holds busy[31:1], async reset.
  - Ports: set_en, set_rd, clr_en, clr_rd, flush.
  - Read ports: two combinational source lookups plus one RD lookup.
- Top level holds the decode, hazard logic, operand mux and output register.

## Test plan
- Reset: hold RST_N low mid-stream with busy[5] set -> all outputs 0, VALID 0; after release, ADD x6,x5,x5 issues without stall.
- RAW: ADDI x5,x0,7 then ADD x6,x5,x0 -> second held, STALL=1 and VALID=0 bubbles until WB_VALID with WB_RD=5. Then issues with RS1_DATA = regfile value; issues 1 cycle after WB with the macro off, same cycle with it on (RS1_DATA = WB_DATA = 7).
- WAW: ADDI x5 pending, then LUI x5 -> STALL until WB_RD=5; x0 destination (ADDI x0,x0,0) never sets busy or stalls.
- Simultaneous: issue ADDI x8 on the same edge as WB_RD=8 -> busy[8] remains 1.
- MEM_WAIT: assert for 3 cycles with a valid instruction at the input -> outputs frozen, no busy set; WB_RD=3 during the wait still clears busy[3].
- FLUSH: with busy[1], busy[2], busy[9] set and a stall active -> next cycle VALID=0, all busy clear, STALL=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: RV32 major opcodes, operand-usage decode and the
// issue-register payload used by the scheduling stages.
package core_pkg;

    typedef enum logic [6:0] {
        BUBBLE = 7'b0000000,
        LOAD   = 7'b0000011,
        OP_IMM = 7'b0010011,
        AUIPC  = 7'b0010111,
        STORE  = 7'b0100011,
        OP     = 7'b0110011,
        LUI    = 7'b0110111,
        BRANCH = 7'b1100011,
        JALR   = 7'b1100111,
        JAL    = 7'b1101111,
        SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic writes_rd;
    } use_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } issue_t;

    // SYSTEM counts as rs1 reader and rd writer so CSR ops are ordered correctly.
    function automatic use_t decode_use(input logic [6:0] opcode);
        use_t u;
        u = '0;
        case (opcode)
            OP:      u = '{use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b1};
            OP_IMM:  u = '{use_rs1: 1'b1, use_rs2: 1'b0, writes_rd: 1'b1};
            LOAD:    u = '{use_rs1: 1'b1, use_rs2: 1'b0, writes_rd: 1'b1};
            STORE:   u = '{use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b0};
            BRANCH:  u = '{use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b0};
            JAL:     u = '{use_rs1: 1'b0, use_rs2: 1'b0, writes_rd: 1'b1};
            JALR:    u = '{use_rs1: 1'b1, use_rs2: 1'b0, writes_rd: 1'b1};
            LUI:     u = '{use_rs1: 1'b0, use_rs2: 1'b0, writes_rd: 1'b1};
            AUIPC:   u = '{use_rs1: 1'b0, use_rs2: 1'b0, writes_rd: 1'b1};
            SYSTEM:  u = '{use_rs1: 1'b1, use_rs2: 1'b0, writes_rd: 1'b1};
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/schedule_2nd_if.sv
// Bundle between schedule_2nd and its neighbours: upstream fields, register
// file read port, writeback, and the issued instruction toward execute.
interface schedule_2nd_if;
    logic        flush;
    logic        mem_wait;
    logic [31:0] schedule_1st_pc;
    logic [31:0] schedule_1st_imm;
    logic [6:0]  schedule_1st_opcode;
    logic [6:0]  schedule_1st_funct7;
    logic [4:0]  schedule_1st_rd;
    logic [4:0]  schedule_1st_rs1;
    logic [4:0]  schedule_1st_rs2;
    logic [2:0]  schedule_1st_funct3;
    logic [4:0]  reg_rs1_addr;
    logic [4:0]  reg_rs2_addr;
    logic [31:0] reg_rs1_data;
    logic [31:0] reg_rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        schedule_2nd_valid;
    logic [31:0] schedule_2nd_pc;
    logic [6:0]  schedule_2nd_opcode;
    logic [4:0]  schedule_2nd_rd;
    logic [2:0]  schedule_2nd_funct3;
    logic [6:0]  schedule_2nd_funct7;
    logic [31:0] schedule_2nd_imm;
    logic [31:0] schedule_2nd_rs1_data;
    logic [31:0] schedule_2nd_rs2_data;

    modport slave (
        input  flush, mem_wait,
        input  schedule_1st_pc, schedule_1st_imm, schedule_1st_opcode, schedule_1st_funct7,
        input  schedule_1st_rd, schedule_1st_rs1, schedule_1st_rs2, schedule_1st_funct3,
        input  reg_rs1_data, reg_rs2_data,
        input  wb_valid, wb_rd, wb_data,
        output reg_rs1_addr, reg_rs2_addr, stall,
        output schedule_2nd_valid, schedule_2nd_pc, schedule_2nd_opcode, schedule_2nd_rd,
        output schedule_2nd_funct3, schedule_2nd_funct7, schedule_2nd_imm,
        output schedule_2nd_rs1_data, schedule_2nd_rs2_data
    );

    modport master (
        output flush, mem_wait,
        output schedule_1st_pc, schedule_1st_imm, schedule_1st_opcode, schedule_1st_funct7,
        output schedule_1st_rd, schedule_1st_rs1, schedule_1st_rs2, schedule_1st_funct3,
        output reg_rs1_data, reg_rs2_data,
        output wb_valid, wb_rd, wb_data,
        input  reg_rs1_addr, reg_rs2_addr, stall,
        input  schedule_2nd_valid, schedule_2nd_pc, schedule_2nd_opcode, schedule_2nd_rd,
        input  schedule_2nd_funct3, schedule_2nd_funct7, schedule_2nd_imm,
        input  schedule_2nd_rs1_data, schedule_2nd_rs2_data
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy bits for x1..x31 marking registers with an outstanding write.
// x0 reads as never busy; a same-edge set beats a clear on the same register.
module reg_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       clr_en,
    input  logic [4:0] clr_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);
    logic [31:1] busy;
    logic [31:0] busy_x;

    assign busy_x   = {busy, 1'b0};
    assign rs1_busy = busy_x[rs1];
    assign rs2_busy = busy_x[rs2];
    assign rd_busy  = busy_x[rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (set_en && set_rd == 5'(i))
                    busy[i] <= 1'b1;
                else if (clr_en && clr_rd == 5'(i))
                    busy[i] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/schedule_2nd.sv
// Issue / operand-fetch stage: RAW/WAW hazard check against the busy scoreboard,
// operand read and one-cycle issue register. Optional macro SCHEDULE_2ND_FORWARD_EN
// bypasses same-cycle writeback data onto the source operands.
module schedule_2nd
    import core_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    schedule_2nd_if.slave bus
);
    use_t        use_dec;
    logic        valid_in;
    logic        writes_rd;
    logic        hazard;
    logic        set_en;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        rs1_busy_eff;
    logic        rs2_busy_eff;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        valid_q;
    issue_t      issue_q;

    assign bus.reg_rs1_addr = bus.schedule_1st_rs1;
    assign bus.reg_rs2_addr = bus.schedule_1st_rs2;

    assign use_dec   = decode_use(bus.schedule_1st_opcode);
    assign valid_in  = (bus.schedule_1st_opcode != 7'd0);
    assign writes_rd = use_dec.writes_rd && (bus.schedule_1st_rd != 5'd0);

`ifdef SCHEDULE_2ND_FORWARD_EN
    logic fwd_rs1;
    logic fwd_rs2;

    assign fwd_rs1      = bus.wb_valid && (bus.wb_rd == bus.schedule_1st_rs1) && (bus.schedule_1st_rs1 != 5'd0);
    assign fwd_rs2      = bus.wb_valid && (bus.wb_rd == bus.schedule_1st_rs2) && (bus.schedule_1st_rs2 != 5'd0);
    assign rs1_busy_eff = rs1_busy && !fwd_rs1;
    assign rs2_busy_eff = rs2_busy && !fwd_rs2;
    assign rs1_data     = fwd_rs1 ? bus.wb_data : bus.reg_rs1_data;
    assign rs2_data     = fwd_rs2 ? bus.wb_data : bus.reg_rs2_data;
`else
    logic unused_wb_data;

    assign unused_wb_data = ^bus.wb_data;
    assign rs1_busy_eff   = rs1_busy;
    assign rs2_busy_eff   = rs2_busy;
    assign rs1_data       = bus.reg_rs1_data;
    assign rs2_data       = bus.reg_rs2_data;
`endif

    // WAW always looks at the raw busy bit: one bit per register cannot track two writers.
    assign hazard = valid_in && ((use_dec.use_rs1 && rs1_busy_eff) ||
                                 (use_dec.use_rs2 && rs2_busy_eff) ||
                                 (writes_rd && rd_busy));
    assign bus.stall = hazard;
    assign set_en    = !bus.flush && !bus.mem_wait && !hazard && valid_in && writes_rd;

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.flush),
        .set_en   (set_en),
        .set_rd   (bus.schedule_1st_rd),
        .clr_en   (bus.wb_valid),
        .clr_rd   (bus.wb_rd),
        .rs1      (bus.schedule_1st_rs1),
        .rs2      (bus.schedule_1st_rs2),
        .rd       (bus.schedule_1st_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            issue_q <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            issue_q <= '0;
        end else if (!bus.mem_wait) begin
            if (hazard) begin
                valid_q <= 1'b0;
                issue_q <= '0;
            end else begin
                valid_q <= valid_in;
                issue_q <= '{pc:       bus.schedule_1st_pc,
                             opcode:   bus.schedule_1st_opcode,
                             rd:       bus.schedule_1st_rd,
                             funct3:   bus.schedule_1st_funct3,
                             funct7:   bus.schedule_1st_funct7,
                             imm:      bus.schedule_1st_imm,
                             rs1_data: rs1_data,
                             rs2_data: rs2_data};
            end
        end
    end

    assign bus.schedule_2nd_valid    = valid_q;
    assign bus.schedule_2nd_pc       = issue_q.pc;
    assign bus.schedule_2nd_opcode   = issue_q.opcode;
    assign bus.schedule_2nd_rd       = issue_q.rd;
    assign bus.schedule_2nd_funct3   = issue_q.funct3;
    assign bus.schedule_2nd_funct7   = issue_q.funct7;
    assign bus.schedule_2nd_imm      = issue_q.imm;
    assign bus.schedule_2nd_rs1_data = issue_q.rs1_data;
    assign bus.schedule_2nd_rs2_data = issue_q.rs2_data;
endmodule
